winograd_conv_loader: RTL
=========================

# winograd_conv_loader

Upstream feeder for `winograd_conv_10x12`. It accepts a serial valid/ready word stream (one 3x3 kernel, then one 10x12 image, both row-major) and assembles the words into the parallel `kernel_out` and `image_out` arrays. It then pulses `conv_start`, waits for `conv_done`, and reports completion. Buffered data stays stable on its outputs until the next load overwrites it.

## Interface
Parameters:
- `DATA_WIDTH`, 32, element width.
- `IMG_ROWS`, 10, image rows.
- `IMG_COLS`, 12, image columns.
- `K_SIZE`, 3, kernel side.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `load_start`  in  1  begins a load sequence; sampled only in IDLE.
- `in_data`  in  DATA_WIDTH  stream word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a word this cycle.
- `kernel_out`  out  DATA_WIDTH x [0:K_SIZE-1][0:K_SIZE-1]  assembled kernel; connects to the conv `kernel_in`.
- `image_out`  out  DATA_WIDTH x [0:IMG_ROWS-1][0:IMG_COLS-1]  assembled image; connects to the conv `image_in`.
- `conv_start`  out  1  one-cycle start pulse to the conv.
- `conv_done`  in  1  completion from the conv.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the sequence completes.

## Operation
- A transfer occurs when `in_valid && in_ready` are both high.
- `in_ready` is high exactly in LOAD_K and LOAD_I. It is a combinational decode of registered state, with no dependency on `in_valid`.
- States and transitions:
  - IDLE: on `load_start` go to LOAD_K; clear `k_idx`, `row`, `col`.
  - LOAD_K: each transfer writes `kernel_out[k_idx/3][k_idx%3]`. The transfer at `k_idx==8` goes to LOAD_I; otherwise `k_idx` increments.
  - LOAD_I: each transfer writes `image_out[row][col]`. `col` wraps 11→0 with `row` incrementing. The transfer at (9,11) goes to FIRE.
  - FIRE: `conv_start`=1 for this single cycle, then go to WAIT.
  - WAIT: hold until `conv_done`=1, then go to FIN. `conv_done` is ignored in every other state.
  - FIN: `done`=1 for this single cycle, then go to IDLE.
- `load_start` is ignored outside IDLE; a second pulse does not restart the sequence.
- No data path arithmetic: words are stored unmodified, full `DATA_WIDTH`. Counters are sized `$clog2` of their range.
- Stream stalls (`in_valid`=0) keep the state, counters and buffers unchanged, for any duration.
- Buffers are written only on transfers. Outside a load they hold their last value, so they stay valid for the conv during WAIT and afterwards.
- Reset, asynchronous and at any time (including mid-load or in WAIT):
  - state goes to IDLE and all counters go to 0;
  - `kernel_out` and `image_out` go to all zeros;
  - `in_ready`, `conv_start`, `busy` and `done` go to 0.

## Timing
- Reset values of all outputs are 0 (arrays all-zero).
- `load_start` sampled high at edge E: `busy`=1 and `in_ready`=1 from E onwards.
- Minimum load with continuous `in_valid` takes 129 transfer cycles (9 kernel + 120 image).
- Last image transfer at edge N: `conv_start`=1 during cycle N→N+1, and the complete image is already visible on `image_out` in that cycle.
- `conv_done` sampled high at edge M in WAIT: `done`=1 during M→M+1; IDLE and `busy`=0 from M+1.
- `load_start` is accepted again from the first IDLE cycle; there are no dead cycles beyond FIN.

## Structure
- Shared package `winograd_pkg` holds:
  - `DATA_WIDTH`, `IMG_ROWS`, `IMG_COLS`, `K_SIZE`;
  - derived `OUT_ROWS`=`IMG_ROWS`-`K_SIZE`+1 and `OUT_COLS`=`IMG_COLS`-`K_SIZE`+1;
  - the `loader_state_t` enum {IDLE, LOAD_K, LOAD_I, FIRE, WAIT, FIN}.
- One sub-module: `winograd_rc_counter`, a parameterised row/column counter with enable, clear, wrap and last flag. It is instanced for the image (10x12) and for the kernel (3x3).

## Test plan
- Nominal load: reset, `load_start`, stream kernel 1..9 then image values `(i*12+j+1)%20`, continuous valid. Expect `kernel_out[2][2]`=9, `image_out[9][11]`=0, `image_out[0][0]`=1, `conv_start` exactly 129 cycles after the first transfer, and `in_ready`=0 afterwards.
- Random stalls: same data with `in_valid` deasserted about 30% of cycles. Expect identical buffer contents, exactly 129 transfers counted, and a single `conv_start` pulse.
- Handshake: model `conv_done` asserted 40 cycles after `conv_start`. Expect `done` one cycle later, `busy` falling with it, and a stray `conv_done` during LOAD_I ignored with no state change.
- Ignored start: pulse `load_start` during LOAD_I at word 50. Expect no restart, counters continue, and the final image is unchanged.
- Reset mid-load: assert `rst_n`=0 after 60 image words. Expect all outputs 0 and buffers zero immediately (async). A subsequent full load with kernel all 7s yields `kernel_out` all 7s.
- Back-to-back: two full sequences with `load_start` in the first IDLE cycle after `done`. Expect the second data set fully replacing the first and two `done` pulses.

Source files
------------

// File: rtl/winograd_pkg.sv
// Shared constants and types for the Winograd 10x12 convolution block and its feeders.
package winograd_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int IMG_ROWS   = 10;
  localparam int IMG_COLS   = 12;
  localparam int K_SIZE     = 3;
  localparam int OUT_ROWS   = IMG_ROWS - K_SIZE + 1;
  localparam int OUT_COLS   = IMG_COLS - K_SIZE + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_K,
    LOAD_I,
    FIRE,
    WAIT,
    FIN
  } loader_state_t;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/winograd_rc_counter.sv
// Row-major row/column counter: col wraps into a row increment, and the whole count
// wraps back to (0,0) after the last position.
module winograd_rc_counter
  import winograd_pkg::*;
#(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  localparam int RW = cnt_w(ROWS),
  localparam int CW = cnt_w(COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  assign last = (row == ROW_MAX) && (col == COL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/winograd_conv_loader.sv
// Serial-to-parallel feeder for winograd_conv_10x12: buffers a 3x3 kernel and a 10x12
// image from a valid/ready stream, then runs one start/done handshake with the conv.
module winograd_conv_loader #(
  parameter int DATA_WIDTH = winograd_pkg::DATA_WIDTH,
  parameter int IMG_ROWS   = winograd_pkg::IMG_ROWS,
  parameter int IMG_COLS   = winograd_pkg::IMG_COLS,
  parameter int K_SIZE     = winograd_pkg::K_SIZE
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                load_start,
  input  logic [DATA_WIDTH-1:0]                               in_data,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  output logic [0:K_SIZE-1][0:K_SIZE-1][DATA_WIDTH-1:0]       kernel_out,
  output logic [0:IMG_ROWS-1][0:IMG_COLS-1][DATA_WIDTH-1:0]   image_out,
  output logic                                                conv_start,
  input  logic                                                conv_done,
  output logic                                                busy,
  output logic                                                done
);
  import winograd_pkg::*;

  localparam int KW  = cnt_w(K_SIZE);
  localparam int IRW = cnt_w(IMG_ROWS);
  localparam int ICW = cnt_w(IMG_COLS);

  loader_state_t  state;
  logic [KW-1:0]  k_row, k_col;
  logic [IRW-1:0] i_row, i_col_r;
  logic [ICW-1:0] i_col;
  logic           k_last, i_last;
  logic           k_xfer, i_xfer, start_load;

  // in_ready is a pure decode of state so the upstream never sees a valid->ready path.
  assign in_ready   = (state == LOAD_K) || (state == LOAD_I);
  assign busy       = (state != IDLE);
  assign k_xfer     = (state == LOAD_K) && in_valid;
  assign i_xfer     = (state == LOAD_I) && in_valid;
  assign start_load = (state == IDLE) && load_start;
  assign i_col_r    = i_row;

  winograd_rc_counter #(.ROWS(K_SIZE), .COLS(K_SIZE)) u_k_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_load),
    .en    (k_xfer),
    .row   (k_row),
    .col   (k_col),
    .last  (k_last)
  );

  winograd_rc_counter #(.ROWS(IMG_ROWS), .COLS(IMG_COLS)) u_i_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_load),
    .en    (i_xfer),
    .row   (i_row),
    .col   (i_col),
    .last  (i_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kernel_out <= '0;
      image_out  <= '0;
    end else begin
      if (k_xfer) kernel_out[k_row][k_col] <= in_data;
      if (i_xfer) image_out[i_col_r][i_col] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      conv_start <= 1'b0;
      done       <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE:   if (load_start) state <= LOAD_K;
        LOAD_K: if (k_xfer && k_last) state <= LOAD_I;
        LOAD_I: if (i_xfer && i_last) begin
          state      <= FIRE;
          conv_start <= 1'b1;
        end
        FIRE:   state <= WAIT;
        WAIT:   if (conv_done) begin
          state <= FIN;
          done  <= 1'b1;
        end
        FIN:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
